// File: rtl/cam_control_pkg.sv
// Shared types for the CAM control block: default sizes, datapath-facing types and FSM states.
// The optional statistics counters in cam_control are enabled with the CAM_STATS_EN macro.
package cam_control_pkg;

  localparam int def_camsize_p   = 8;
  localparam int def_key_width_p = 16;
  localparam int def_val_width_p = 32;
  localparam int def_idx_width_p = $clog2(def_camsize_p);

  typedef logic [def_idx_width_p-1:0] idx_t;
  typedef logic [def_key_width_p-1:0] key_t;
  typedef logic [def_val_width_p-1:0] val_t;
  typedef logic [def_camsize_p-1:0]   camvec_t;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    UPDATE,
    RESP
  } state_e;

endpackage

// File: rtl/cam_control_victim_sel.sv
// Combinational target selection: lowest hit, else lowest invalid entry, else the LRU entry.
module cam_victim_sel #(
  parameter int camsize_p = 8,
  parameter int idx_w     = $clog2(camsize_p)
) (
  input  logic [camsize_p-1:0]            hits_i,
  input  logic [camsize_p-1:0]            valids_i,
  input  logic [camsize_p-1:0][idx_w-1:0] lrus_i,
  output logic [idx_w-1:0]                target_o,
  output logic                            hit_o,
  output logic                            multi_hit_o
);

  localparam logic [idx_w-1:0] lru_age = idx_w'(camsize_p - 1);

  logic [idx_w-1:0] hit_idx;
  logic [idx_w-1:0] inv_idx;
  logic [idx_w-1:0] lru_idx;
  logic             any_inv;

  // Scanning from the top down leaves the lowest matching index in each result.
  always_comb begin
    hit_idx = '0;
    inv_idx = '0;
    lru_idx = '0;
    any_inv = 1'b0;
    for (int i = camsize_p - 1; i >= 0; i--) begin
      if (hits_i[i]) hit_idx = i[idx_w-1:0];
      if (!valids_i[i]) begin
        inv_idx = i[idx_w-1:0];
        any_inv = 1'b1;
      end
      if (lrus_i[i] == lru_age) lru_idx = i[idx_w-1:0];
    end
  end

  assign hit_o       = |hits_i;
  assign multi_hit_o = |(hits_i & (hits_i - camsize_p'(1)));
  assign target_o    = hit_o ? hit_idx : (any_inv ? inv_idx : lru_idx);

endmodule

// File: rtl/cam_control.sv
// CAM control FSM: request/response handshakes, hit evaluation and per-entry update vectors.
// Define CAM_STATS_EN to add saturating hit/miss counters (hit_cnt_o, miss_cnt_o).
module cam_control
  import cam_control_pkg::*;
#(
  parameter int camsize_p   = def_camsize_p,
  parameter int key_width_p = def_key_width_p,
  parameter int val_width_p = def_val_width_p,
  parameter int idx_w       = $clog2(camsize_p)
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic                            req_write_i,
  input  logic [key_width_p-1:0]          req_key_i,
  input  logic [val_width_p-1:0]          req_val_i,
  output logic                            resp_valid_o,
  input  logic                            resp_ready_i,
  output logic                            resp_hit_o,
  output logic [idx_w-1:0]                resp_idx_o,
  output logic [key_width_p-1:0]          key_o,
  output logic [val_width_p-1:0]          val_o,
  input  logic [camsize_p-1:0]            hits_i,
  input  logic [camsize_p-1:0]            valids_i,
  input  logic [camsize_p-1:0][idx_w-1:0] lrus_i,
  output logic [camsize_p-1:0]            read_c_o,
  output logic [camsize_p-1:0]            write_c_o,
  output logic [camsize_p-1:0]            increment_lru_c_o,
`ifdef CAM_STATS_EN
  output logic [15:0]                     hit_cnt_o,
  output logic [15:0]                     miss_cnt_o,
`endif
  output logic [idx_w-1:0]                read_idx_o
);

  state_e                 state_q;
  logic                   op_write_q;
  logic [camsize_p-1:0]   rd_q;
  logic [camsize_p-1:0]   wr_q;
  logic [camsize_p-1:0]   inc_q;

  logic [idx_w-1:0]       vs_target;
  logic                   vs_hit;
  logic                   vs_multi;
  logic [camsize_p-1:0]   one_hot;
  logic [camsize_p-1:0]   inc_next;
  logic [idx_w-1:0]       touched_age;
  logic                   read_miss;

  cam_victim_sel #(
    .camsize_p (camsize_p),
    .idx_w     (idx_w)
  ) u_victim_sel (
    .hits_i      (hits_i),
    .valids_i    (valids_i),
    .lrus_i      (lrus_i),
    .target_o    (vs_target),
    .hit_o       (vs_hit),
    .multi_hit_o (vs_multi)
  );

  assign one_hot     = {{(camsize_p-1){1'b0}}, 1'b1} << vs_target;
  assign touched_age = lrus_i[vs_target];
  assign read_miss   = !vs_hit && !op_write_q;

  // Every entry younger than the touched one ages by one; the target itself never satisfies
  // the strict compare, so ages remain a permutation and cannot wrap.
  always_comb begin
    inc_next = '0;
    for (int j = 0; j < camsize_p; j++) begin
      if (lrus_i[j] < touched_age) inc_next[j] = 1'b1;
    end
  end

  // Reset is sampled at the edge, so the vectors registered for UPDATE are masked directly
  // while reset is low to keep the datapath from acting on a dropped op.
  assign read_c_o          = rd_q  & {camsize_p{reset_n_i}};
  assign write_c_o         = wr_q  & {camsize_p{reset_n_i}};
  assign increment_lru_c_o = inc_q & {camsize_p{reset_n_i}};

  // NOTE: all state here is updated with non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      op_write_q   <= 1'b0;
      req_ready_o  <= 1'b1;
      resp_valid_o <= 1'b0;
      resp_hit_o   <= 1'b0;
      resp_idx_o   <= '0;
      read_idx_o   <= '0;
      key_o        <= '0;
      val_o        <= '0;
      rd_q         <= '0;
      wr_q         <= '0;
      inc_q        <= '0;
`ifdef CAM_STATS_EN
      hit_cnt_o    <= '0;
      miss_cnt_o   <= '0;
`endif
    end else begin
      // NOTE: the vectors default to zero each cycle so they pulse for exactly the UPDATE cycle.
      rd_q  <= '0;
      wr_q  <= '0;
      inc_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            op_write_q  <= req_write_i;
            key_o       <= req_key_i;
            val_o       <= req_val_i;
            req_ready_o <= 1'b0;
            state_q     <= LOOKUP;
          end
        end
        LOOKUP: begin
          resp_hit_o <= vs_hit;
          if (read_miss) begin
            resp_idx_o   <= '0;
            read_idx_o   <= '0;
            resp_valid_o <= 1'b1;
            state_q      <= RESP;
          end else begin
            resp_idx_o <= vs_target;
            read_idx_o <= vs_target;
            inc_q      <= inc_next;
            if (op_write_q) wr_q <= one_hot;
            else            rd_q <= one_hot;
            state_q    <= UPDATE;
          end
`ifdef CAM_STATS_EN
          if (vs_hit) begin
            if (hit_cnt_o != 16'hFFFF) hit_cnt_o <= hit_cnt_o + 16'd1;
          end else begin
            if (miss_cnt_o != 16'hFFFF) miss_cnt_o <= miss_cnt_o + 16'd1;
          end
`endif
        end
        UPDATE: begin
          resp_valid_o <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
            req_ready_o  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Duplicate keys in the datapath indicate a corrupted CAM; the lowest index is used anyway.
  a_single_hit : assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                  (state_q == LOOKUP) |-> !vs_multi);

endmodule

// File: tb/tb_cam_control.sv
// Self-checking bench for cam_control: a datapath model drives hits/valids/ages, and a
// reference CAM (key table plus MRU-ordered queue) predicts every response and vector.
module tb_cam_control;

  localparam int N   = 8;
  localparam int IW  = 3;
  localparam int KW  = 16;
  localparam int VW  = 32;
  localparam int BIG = 1 << 30;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  req_valid, req_ready, req_write;
  logic [KW-1:0]         req_key;
  logic [VW-1:0]         req_val;
  logic                  resp_valid, resp_ready, resp_hit;
  logic [IW-1:0]         resp_idx, read_idx;
  logic [KW-1:0]         key_o;
  logic [VW-1:0]         val_o;
  logic [N-1:0]          hits, valids;
  logic [N-1:0][IW-1:0]  lrus;
  logic [N-1:0]          read_c, write_c, inc_c;
`ifdef CAM_STATS_EN
  logic [15:0]           hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  cam_control #(.camsize_p(N), .key_width_p(KW), .val_width_p(VW)) dut (
    .clk_i             (clk),
    .reset_n_i         (reset_n),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_write_i       (req_write),
    .req_key_i         (req_key),
    .req_val_i         (req_val),
    .resp_valid_o      (resp_valid),
    .resp_ready_i      (resp_ready),
    .resp_hit_o        (resp_hit),
    .resp_idx_o        (resp_idx),
    .key_o             (key_o),
    .val_o             (val_o),
    .hits_i            (hits),
    .valids_i          (valids),
    .lrus_i            (lrus),
    .read_c_o          (read_c),
    .write_c_o         (write_c),
    .increment_lru_c_o (inc_c),
`ifdef CAM_STATS_EN
    .hit_cnt_o         (hit_cnt),
    .miss_cnt_o        (miss_cnt),
`endif
    .read_idx_o        (read_idx)
  );

  // Datapath environment: entry i starts with age N-1-i.
  logic [KW-1:0] dp_key [N];
  logic [VW-1:0] dp_val [N];
  logic          dp_vld [N];
  logic [IW-1:0] dp_age [N];
  logic          dp_clear;

  always_comb begin
    hits   = '0;
    valids = '0;
    lrus   = '0;
    for (int i = 0; i < N; i++) begin
      hits[i]   = dp_vld[i] && (dp_key[i] == key_o);
      valids[i] = dp_vld[i];
      lrus[i]   = dp_age[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (dp_clear) begin
        dp_vld[i] <= 1'b0;
        dp_key[i] <= '0;
        dp_val[i] <= '0;
        dp_age[i] <= IW'(N - 1 - i);
      end else if (write_c[i]) begin
        dp_vld[i] <= 1'b1;
        dp_key[i] <= key_o;
        dp_val[i] <= val_o;
        dp_age[i] <= '0;
      end else if (read_c[i]) begin
        dp_age[i] <= '0;
      end else if (inc_c[i]) begin
        dp_age[i] <= dp_age[i] + 1'b1;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference CAM: key/value table plus a queue of entry numbers ordered MRU first.
  logic [KW-1:0] rk [N];
  logic [VW-1:0] rv [N];
  bit            rvld [N];
  int            lru_q[$];

  int            exp_acc, exp_upd, exp_resp, exp_end, e_lat, e_idx;
  logic [N-1:0]  e_rd, e_wr, e_inc;
  bit            e_hit, e_rdhit;
  logic [VW-1:0] e_val;
  bit            chk_en;
  logic [N-1:0]  cap_rd, cap_wr, cap_inc;
  bit            got_hit;
  logic [IW-1:0] got_idx;
  logic [VW-1:0] got_val;

  task automatic ref_reset();
    lru_q = {};
    for (int i = N - 1; i >= 0; i--) begin
      rvld[i] = 1'b0;
      rk[i]   = '0;
      rv[i]   = '0;
      lru_q.push_back(i);
    end
  endtask

  task automatic clear_expect();
    exp_acc  = BIG;
    exp_upd  = -1;
    exp_resp = BIG;
    exp_end  = BIG;
  endtask

  task automatic model_op(input bit wr, input logic [KW-1:0] key, input logic [VW-1:0] val);
    int t;
    int pos;
    t = -1;
    for (int i = 0; i < N; i++) if (t < 0 && rvld[i] && rk[i] == key) t = i;
    e_hit = (t >= 0);
    if (!e_hit && wr) begin
      for (int i = 0; i < N; i++) if (t < 0 && !rvld[i]) t = i;
      if (t < 0) t = lru_q[lru_q.size() - 1];
    end
    e_rd = '0; e_wr = '0; e_inc = '0;
    e_rdhit = !wr && e_hit;
    if (t < 0) begin
      e_idx = 0;
      e_lat = 2;
    end else begin
      e_idx = t;
      e_lat = 3;
      pos = 0;
      for (int k = 0; k < lru_q.size(); k++) if (lru_q[k] == t) pos = k;
      for (int k = 0; k < pos; k++) e_inc[lru_q[k]] = 1'b1;
      lru_q.delete(pos);
      lru_q.push_front(t);
      if (wr) begin
        e_wr[t] = 1'b1;
        rk[t] = key; rv[t] = val; rvld[t] = 1'b1;
      end else begin
        e_rd[t] = 1'b1;
      end
      e_val = rv[t];
    end
  endtask

  // Compare process: checks vectors, handshakes and response fields every cycle.
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      if (cyc == exp_upd) begin
        check("read_c", read_c, e_rd);
        check("write_c", write_c, e_wr);
        check("increment_lru_c", inc_c, e_inc);
        cap_rd = read_c; cap_wr = write_c; cap_inc = inc_c;
      end else begin
        check("vectors_idle", {read_c, write_c, inc_c}, '0);
      end
      check("vector_overlap", (read_c & write_c) | (read_c & inc_c) | (write_c & inc_c), '0);
      check("req_ready", req_ready, !(cyc > exp_acc && cyc <= exp_end));
      check("resp_valid", resp_valid, (cyc >= exp_resp && cyc <= exp_end));
      if (cyc >= exp_resp && cyc <= exp_end) begin
        check("resp_hit", resp_hit, e_hit);
        check("resp_idx", resp_idx, e_idx);
        if (e_lat == 3) check("read_idx", read_idx, e_idx);
        if (e_rdhit) check("read_data", dp_val[read_idx], e_val);
      end
    end
  end

  task automatic do_op(input bit wr, input logic [KW-1:0] key, input logic [VW-1:0] val,
                       input int stall);
    int n;
    int st;
    st = stall;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin check("req_ready_timeout", 0, 1); return; end
    model_op(wr, key, val);
    exp_acc  = cyc;
    exp_upd  = (e_lat == 3) ? cyc + 2 : -1;
    exp_resp = cyc + e_lat;
    exp_end  = BIG;
    req_valid = 1'b1; req_write = wr; req_key = key; req_val = val;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0; req_key = '0; req_val = '0;
    n = 0;
    while (n < 30) begin
      if (resp_valid) begin
        if (st == 0) break;
        st--;
      end
      @(negedge clk);
      n++;
    end
    if (!resp_valid) begin check("resp_timeout", 0, 1); return; end
    got_hit = resp_hit;
    got_idx = resp_idx;
    got_val = dp_val[read_idx];
    resp_ready = 1'b1;
    exp_end = cyc;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_vectors"}, {read_c, write_c, inc_c}, '0);
    check({tag, "_key_val"}, {key_o, val_o}, '0);
    check({tag, "_resp_fields"}, {resp_hit, resp_idx, read_idx}, '0);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    reset_n = 1'b0;
    dp_clear = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    dp_clear = 1'b0;
    ref_reset();
    clear_expect();
    check_reset_state("reset");
    chk_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int cnt;
    req_valid = 0; req_write = 0; req_key = '0; req_val = '0; resp_ready = 0;
    cap_rd = '0; cap_wr = '0; cap_inc = '0;
    clear_expect();
    do_reset();

    // 1: read miss on an empty CAM
    do_op(0, 16'h1234, '0, 0);
    check("t1_hit", got_hit, 0);
    check("t1_idx", got_idx, 0);

    // 2: first write lands in entry 0 and ages every other entry
    cap_wr = '0; cap_inc = '0;
    do_op(1, 16'h1234, 32'hDEADBEEF, 0);
    check("t2_write_c", cap_wr, 8'b0000_0001);
    check("t2_inc", cap_inc, 8'b1111_1110);
    check("t2_idx_hit", {got_hit, got_idx}, {1'b0, 3'd0});
    do_op(0, 16'h1234, '0, 0);
    check("t2_read", {got_hit, got_idx, got_val}, {1'b1, 3'd0, 32'hDEADBEEF});

    // 3: fill, refresh entry 0, then evict the LRU entry (1)
    do_reset();
    for (int i = 0; i < N; i++) do_op(1, KW'(16'h0100 + i), VW'(32'h1000 + i), 0);
    do_op(0, 16'h0100, '0, 0);
    check("t3_read0", {got_hit, got_idx, got_val}, {1'b1, 3'd0, 32'h1000});
    do_op(1, 16'h0999, 32'h9999, 0);
    check("t3_victim", {got_hit, got_idx}, {1'b0, 3'd1});
    do_op(0, 16'h0100, '0, 0);
    check("t3_retained", {got_hit, got_idx, got_val}, {1'b1, 3'd0, 32'h1000});
    do_op(0, 16'h0101, '0, 0);
    check("t3_evicted", got_hit, 0);

    // 4: overwrite an existing key in place
    do_op(1, 16'h0105, 32'hCAFEF00D, 0);
    check("t4_write", {got_hit, got_idx}, {1'b1, 3'd5});
    do_op(0, 16'h0105, '0, 0);
    check("t4_read", {got_hit, got_idx, got_val}, {1'b1, 3'd5, 32'hCAFEF00D});
    cnt = 0;
    for (int i = 0; i < N; i++) if (dp_vld[i] && dp_key[i] == 16'h0105) cnt++;
    check("t4_no_duplicate", cnt, 1);

    // 5: response back-pressure for five cycles
    do_op(0, 16'h0102, '0, 5);
    check("t5_read", {got_hit, got_idx, got_val}, {1'b1, 3'd2, 32'h1002});

    // 6: reset asserted during UPDATE drops the op
    chk_en = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_key = 16'h0777; req_val = 32'h5;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0; req_key = '0; req_val = '0;
    @(posedge clk);
    #1 reset_n = 1'b0;
    #3 check("t6_vectors_in_reset", {read_c, write_c, inc_c}, '0);
    check("t6_resp_valid_in_reset", resp_valid, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check_reset_state("t6");
    cnt = 0;
    for (int i = 0; i < N; i++) if (dp_vld[i] && dp_key[i] == 16'h0777) cnt++;
    check("t6_not_written", cnt, 0);
    clear_expect();
    chk_en = 1'b1;

    // 3 hits + 2 misses after reset
    do_op(0, 16'h0103, '0, 0);
    check("t6_read3", {got_hit, got_idx, got_val}, {1'b1, 3'd3, 32'h1003});
    do_op(0, 16'h0100, '0, 0);
    do_op(0, 16'h0105, '0, 0);
    do_op(0, 16'h0555, '0, 0);
    do_op(0, 16'h0556, '0, 0);
    check("t6_last_miss", got_hit, 0);
`ifdef CAM_STATS_EN
    check("stats_hits", hit_cnt, 16'd3);
    check("stats_misses", miss_cnt, 16'd2);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
